// File: rtl/ir_prefetch.sv
// Instruction register with a small circular prefetch queue and two-byte
// instruction assembly: the head is decoded and exposed only once complete.
module ir_prefetch #(
  parameter int WIDTH    = 8,
  parameter int OPCODE_W = 4,
  parameter int DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          din,
  input  logic                      issue,
  output logic                      instr_valid,
  output logic                      is_long,
  output logic [OPCODE_W-1:0]       opcode,
  output logic [WIDTH-OPCODE_W-1:0] operand,
  output logic [WIDTH-1:0]          ext_operand,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    pop_size;
  logic [WIDTH-1:0] head, second;
  logic             long_head;
  logic             push, pop;

  // The second byte sits one slot past the head; the pointer width makes it wrap.
  assign head      = mem_q[rd_ptr_q];
  assign second    = mem_q[rd_ptr_q + PW'(1)];
  assign long_head = head[WIDTH-1];

  assign in_ready    = (count_q < FULL);
  assign instr_valid = (count_q != '0) && (!long_head || count_q >= CW'(2));

  assign is_long     = instr_valid & long_head;
  assign opcode      = instr_valid ? head[WIDTH-1 -: OPCODE_W] : '0;
  assign operand     = instr_valid ? head[WIDTH-OPCODE_W-1:0] : '0;
  assign ext_operand = is_long ? second : '0;
  assign count       = count_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push     = in_valid & in_ready & ~flush;
    pop      = issue & instr_valid & ~flush;
    pop_size = long_head ? CW'(2) : CW'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + pop_size[PW-1:0];
      count_d = count_q + CW'(push) - (pop ? pop_size : '0);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale data is never exposed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: tb/tb_ir_prefetch.sv
// Self-checking bench for ir_prefetch: directed scenarios plus random traffic,
// all checked against a byte-queue reference model.
module tb_ir_prefetch;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] din = 8'h00;
  logic       issue = 1'b0;
  logic       instr_valid;
  logic       is_long;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic [7:0] ext_operand;
  logic [2:0] count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mq[$];

  ir_prefetch #(.WIDTH(8), .OPCODE_W(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .din(din), .issue(issue),
    .instr_valid(instr_valid), .is_long(is_long), .opcode(opcode),
    .operand(operand), .ext_operand(ext_operand), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_valid();
    if (mq.size() == 0) return 1'b0;
    return !mq[0][7] || mq.size() >= 2;
  endfunction

  task automatic check_outputs(input string tag);
    bit         v;
    logic [7:0] h, x;
    v = m_valid();
    h = v ? mq[0] : 8'h00;
    x = (v && mq[0][7]) ? mq[1] : 8'h00;
    check({tag, ".count"},    32'(count),       32'(mq.size()));
    check({tag, ".in_ready"}, 32'(in_ready),    32'(mq.size() < DEPTH));
    check({tag, ".valid"},    32'(instr_valid), 32'(v));
    check({tag, ".is_long"},  32'(is_long),     32'(v && h[7]));
    check({tag, ".opcode"},   32'(opcode),      32'(h >> 4));
    check({tag, ".operand"},  32'(operand),     32'(h % 16));
    check({tag, ".ext"},      32'(ext_operand), 32'(x));
  endtask

  // Reference model: one edge of queue behaviour from the pre-edge state.
  task automatic model_step(input bit f, input bit v, input logic [7:0] d, input bit i);
    bit rdy, vld;
    rdy = mq.size() < DEPTH;
    vld = m_valid();
    if (f) begin
      mq.delete();
    end else begin
      if (i && vld) begin
        if (mq[0][7]) void'(mq.pop_front());
        void'(mq.pop_front());
      end
      if (v && rdy) mq.push_back(d);
    end
  endtask

  // Called just after a falling edge; outputs are checked mid-cycle.
  task automatic cycle(input string tag, input bit f, input bit v,
                       input logic [7:0] d, input bit i);
    flush = f; in_valid = v; din = d; issue = i;
    check_outputs(tag);
    model_step(f, v, d, i);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; issue = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    reset = 1'b1;

    // Short instruction push then issue.
    cycle("t1_push", 0, 1, 8'h35, 0);
    check("t1_opcode", 32'(opcode), 32'h3);
    check("t1_operand", 32'(operand), 32'h5);
    cycle("t1_issue", 0, 0, 8'h00, 1);
    check_outputs("t1_after");

    // Long instruction only visible once both bytes are queued.
    cycle("t2_b0", 0, 1, 8'hE5, 0);
    check("t2_partial_valid", 32'(instr_valid), 32'd0);
    check("t2_partial_opcode", 32'(opcode), 32'd0);
    cycle("t2_b1", 0, 1, 8'h42, 0);
    check("t2_ext", 32'(ext_operand), 32'h42);
    check("t2_opcode", 32'(opcode), 32'hE);
    cycle("t2_issue", 0, 0, 8'h00, 1);
    check_outputs("t2_after");

    // Fill, drop when full, drain in order.
    foreach (mq[k]) ;
    cycle("t3_p0", 0, 1, 8'h11, 0);
    cycle("t3_p1", 0, 1, 8'h22, 0);
    cycle("t3_p2", 0, 1, 8'h33, 0);
    cycle("t3_p3", 0, 1, 8'h44, 0);
    check("t3_full_ready", 32'(in_ready), 32'd0);
    cycle("t3_drop", 0, 1, 8'h55, 0);
    for (int k = 0; k < 4; k++) begin
      check("t3_head", 32'({opcode, operand}), 32'(8'h11 * (k + 1)));
      cycle("t3_iss", 0, 0, 8'h00, 1);
    end
    check_outputs("t3_empty");

    // Long instruction straddling the wrap point.
    do_reset();
    cycle("t4_a", 0, 1, 8'h10, 0);
    cycle("t4_b", 0, 1, 8'h20, 0);
    cycle("t4_c", 0, 1, 8'h30, 0);
    repeat (3) cycle("t4_iss", 0, 0, 8'h00, 1);
    cycle("t4_l0", 0, 1, 8'hA7, 0);
    cycle("t4_l1", 0, 1, 8'h99, 0);
    check("t4_opcode", 32'(opcode), 32'hA);
    check("t4_operand", 32'(operand), 32'h7);
    check("t4_ext", 32'(ext_operand), 32'h99);
    cycle("t4_issue", 0, 0, 8'h00, 1);

    // Simultaneous push and issue.
    cycle("t5_a", 0, 1, 8'h12, 0);
    cycle("t5_b", 0, 1, 8'h23, 0);
    cycle("t5_both", 0, 1, 8'h66, 1);
    check("t5_count", 32'(count), 32'd2);
    check("t5_head", 32'({opcode, operand}), 32'h23);
    cycle("t5_iss", 0, 0, 8'h00, 1);
    check("t5_last", 32'({opcode, operand}), 32'h66);
    cycle("t5_iss2", 0, 0, 8'h00, 1);

    // Flush beats a same-cycle push.
    cycle("t6_a", 0, 1, 8'h01, 0);
    cycle("t6_b", 0, 1, 8'h02, 0);
    cycle("t6_c", 0, 1, 8'h03, 0);
    cycle("t6_flush", 1, 1, 8'h77, 1);
    check("t6_count", 32'(count), 32'd0);
    check("t6_valid", 32'(instr_valid), 32'd0);

    // Asynchronous reset mid-cycle discards a partial long instruction.
    cycle("t7_a", 0, 1, 8'h35, 0);
    cycle("t7_b", 0, 1, 8'hE5, 0);
    cycle("t7_c", 0, 0, 8'h00, 1);
    #2;
    reset = 1'b0;
    #1;
    mq.delete();
    check_outputs("t7_async");
    @(negedge clk);
    reset = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cycle("rnd", ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6),
            8'($urandom), ($urandom_range(0, 1) == 1));
    end
    check_outputs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
